key_anti_shake2: RTL and testbench
==================================

// Module: key_anti_shake2
// PURPOSE
// - Debounces one mechanical push-button input for the board top level.
// - Samples the raw key on clk and resynchronises it into the clk domain.
// - key_out changes only after the synchronised input has held a new level for STABLE_CYCLES consecutive clocks.
// - Also emits single-cycle press/release pulses for downstream control logic (e.g. single-step clocking of the CPU).
// PARAMETERS
// - STABLE_CYCLES  1_000_000  clocks the level must hold before acceptance (20 ms @ 50 MHz); legal range >=1.
// - CNT_W          20         counter width; must satisfy 2**CNT_W > STABLE_CYCLES.
// - IDLE_LEVEL     1'b0       released (idle) key level; also the reset value of key_out.
// PORTS
// - clk          in   1      system clock; all logic is rising-edge.
// - rst          in   1      synchronous, active-high reset.
// - key_in       in   1      raw asynchronous key level (1 = pressed when IDLE_LEVEL=0).
// - key_out      out  1      debounced key level.
// - key_press    out  1      1-clk pulse when key_out goes IDLE_LEVEL -> ~IDLE_LEVEL.
// - key_release  out  1      1-clk pulse when key_out goes ~IDLE_LEVEL -> IDLE_LEVEL.
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset (rst=1 at a clk edge): sync_q0 = sync_q1 = IDLE_LEVEL, cnt = 0, key_out = IDLE_LEVEL, key_press = key_release = 0.
// - Synchroniser: sync_q0 <= key_in; sync_q1 <= sync_q0. Only sync_q1 feeds the filter.
// - Each clock:
//   - if sync_q1 == key_out: cnt <= 0.
//   - else if cnt == STABLE_CYCLES-1: key_out <= sync_q1; cnt <= 0; the matching pulse fires for exactly that cycle.
//   - else cnt <= cnt + 1.
// - Latency: a clean edge on key_in reaches key_out after 2 + STABLE_CYCLES clocks.
// - Glitch rejection: any return of sync_q1 to key_out's level before acceptance clears cnt; a bounce shorter than STABLE_CYCLES never changes key_out.
// - Pulses: key_press and key_release are registered; never both high; high for exactly one clock per accepted change.
// - cnt never exceeds STABLE_CYCLES-1, so no wrap-around.
// - Reset mid-count discards the partial count; key_out returns to IDLE_LEVEL even if the key is held.
// - After reset, a held key is re-accepted after 2 + STABLE_CYCLES clocks.
// - X on key_in before first drive: reset dominates; no X may propagate past sync once rst has been asserted.
// STRUCTURE
// - Single module; no shared package needed.
// - The 2-flop synchroniser is a natural sub-module: key_sync2 (ports clk, rst, d, q; reset value parameterised).
// - Counter/compare logic and pulse registers live in key_anti_shake2.
// TESTING (sim with STABLE_CYCLES=4, CNT_W=3, IDLE_LEVEL=0)
// 1. rst=1 for 2 clks, key_in=0 -> key_out=0, key_press=key_release=0, cnt=0.
// 2. key_in 0->1 held 20 clks -> key_out=1 exactly 6 clks after the sampling edge; key_press=1 for that single clk.
// 3. key_in high-low-high bounces of 1-3 clks each, then steady 0 -> key_out unchanged until 4 stable clks; no spurious pulses.
// 4. From key_out=1, key_in=0 held -> key_out=0 after 6 clks; key_release=1 for one clk.
// 5. key_in=1 held, rst pulsed after 3 clks of counting -> key_out stays 0 through reset; re-rises 6 clks after rst drops.
// 6. key_in toggling every clk for 50 clks -> key_out constant, key_press=key_release=0 throughout.

Source files
------------

// File: rtl/key_anti_shake2_pkg.sv
// Shared types and default parameters for the key debouncer.
package key_anti_shake2_pkg;

    localparam int   DEF_STABLE_CYCLES = 1_000_000;
    localparam int   DEF_CNT_W         = 20;
    localparam logic DEF_IDLE_LEVEL    = 1'b0;

    typedef enum logic [1:0] {
        KEY_EV_NONE,
        KEY_EV_PRESS,
        KEY_EV_RELEASE
    } key_event_e;

    // An accepted level equal to the idle level is a release, anything else a press.
    function automatic key_event_e classify_change(input logic new_level, input logic idle_level);
        return (new_level == idle_level) ? KEY_EV_RELEASE : KEY_EV_PRESS;
    endfunction

endpackage

// File: rtl/key_anti_shake2_if.sv
// Key level in, debounced level and edge pulses out.
interface key_anti_shake2_if;
    logic key_in;
    logic key_out;
    logic key_press;
    logic key_release;

    modport master (output key_in, input key_out, input key_press, input key_release);
    modport slave  (input key_in, output key_out, output key_press, output key_release);
endinterface

// File: rtl/key_anti_shake2_sync2.sv
// Two-flop synchroniser bringing the raw key level into the clk domain.
module key_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic q0_d, q0_q;
    logic q1_d, q1_q;

    always_comb begin
        q0_d = d;
        q1_d = q0_q;
    end

    // NOTE: non-blocking assignments let both stages update from pre-edge values, forming a real 2-stage shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            q0_q <= RST_VAL;
            q1_q <= RST_VAL;
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end

    assign q = q1_q;

endmodule

// File: rtl/key_anti_shake2.sv
// Push-button debouncer: accepts a new level after it holds for STABLE_CYCLES clocks.
module key_anti_shake2
    import key_anti_shake2_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter logic IDLE_LEVEL    = DEF_IDLE_LEVEL
) (
    input  logic              clk,
    input  logic              rst,
    key_anti_shake2_if.slave  key
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_key;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             key_out_d, key_out_q;
    logic             key_press_d, key_press_q;
    logic             key_release_d, key_release_q;
    key_event_e       change_ev;

    key_sync2 #(.RST_VAL(IDLE_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key.key_in),
        .q   (sync_key)
    );

    // Any cycle where the synchronised level agrees with key_out restarts the hold count.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        cnt_d     = '0;
        key_out_d = key_out_q;
        change_ev = KEY_EV_NONE;
        if (sync_key != key_out_q) begin
            if (cnt_q == CNT_LAST) begin
                key_out_d = sync_key;
                change_ev = classify_change(sync_key, IDLE_LEVEL);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        key_press_d   = (change_ev == KEY_EV_PRESS);
        key_release_d = (change_ev == KEY_EV_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            key_out_q     <= IDLE_LEVEL;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            key_out_q     <= key_out_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key.key_out     = key_out_q;
    assign key.key_press   = key_press_q;
    assign key.key_release = key_release_q;

endmodule

// File: tb/tb_key_anti_shake2.sv
// Randomised and directed bench for key_anti_shake2 against a run-length reference model.
module tb_key_anti_shake2;

    localparam int   S    = 4;
    localparam logic IDLE = 1'b0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_anti_shake2_if kif();

    key_anti_shake2 #(
        .STABLE_CYCLES (S),
        .CNT_W         (3),
        .IDLE_LEVEL    (IDLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .key (kif)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the filter sees key_in two clocks late and accepts a level
    // once it has differed from the output for S edges in a row.
    bit   pipe[$];
    int   streak;
    logic m_out, m_press, m_release;

    function automatic void model_edge(input logic k, input logic r);
        bit v;
        m_press   = 1'b0;
        m_release = 1'b0;
        if (r) begin
            pipe   = '{IDLE, IDLE};
            streak = 0;
            m_out  = IDLE;
        end else begin
            v = pipe.pop_front();
            pipe.push_back(k);
            if (v == m_out) begin
                streak = 0;
            end else begin
                streak++;
                if (streak == S) begin
                    m_out  = v;
                    streak = 0;
                    if (v != IDLE) m_press = 1'b1;
                    else           m_release = 1'b1;
                end
            end
        end
    endfunction

    task automatic tick(input logic k, input logic r);
        kif.key_in = k;
        rst        = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'bx, 1'b1);
            total++;
            if ({kif.key_out, kif.key_press, kif.key_release} !== 3'b000) begin
                bad++;
                $display("FAIL reset cyc=%0d out/press/rel got=%b%b%b want=000",
                         i, kif.key_out, kif.key_press, kif.key_release);
            end
        end
        total++;
        if (dut.cnt_q !== 3'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d want=0", dut.cnt_q);
        end
    endtask

    task automatic test_press();
        int rise = 0;
        int npress = 0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            if (kif.key_out === 1'b1 && rise == 0) rise = i;
            if (kif.key_press === 1'b1) npress++;
            total++;
            if ({kif.key_out, kif.key_press, kif.key_release} !== {m_out, m_press, m_release}) begin
                bad++;
                $display("FAIL press cyc=%0d got=%b%b%b want=%b%b%b", i, kif.key_out,
                         kif.key_press, kif.key_release, m_out, m_press, m_release);
            end
        end
        total++;
        if (rise != 6 || npress != 1) begin
            bad++;
            $display("FAIL press_latency rise_tick=%0d presses=%0d want 6 and 1", rise, npress);
        end
    endtask

    task automatic test_bounce();
        logic lvl = 1'b0;
        int   n;
        for (int seg = 0; seg < 4; seg++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                tick(lvl, 1'b0);
                total++;
                if ({kif.key_out, kif.key_press, kif.key_release} !== 3'b100 ||
                    {m_out, m_press, m_release} !== 3'b100) begin
                    bad++;
                    $display("FAIL bounce seg=%0d got=%b%b%b model=%b%b%b want=100", seg,
                             kif.key_out, kif.key_press, kif.key_release, m_out, m_press, m_release);
                end
            end
            lvl = ~lvl;
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if ({kif.key_out, kif.key_press, kif.key_release} !== {m_out, m_press, m_release}) begin
                bad++;
                $display("FAIL bounce_settle cyc=%0d got=%b%b%b want=%b%b%b", i, kif.key_out,
                         kif.key_press, kif.key_release, m_out, m_press, m_release);
            end
        end
        total++;
        if (kif.key_out !== 1'b0) begin
            bad++;
            $display("FAIL bounce_final got=%b want=0", kif.key_out);
        end
    endtask

    task automatic test_release();
        int fall = 0;
        int nrel = 0;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        total++;
        if (kif.key_out !== 1'b1) begin
            bad++;
            $display("FAIL release_setup got=%b want=1", kif.key_out);
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b0);
            if (kif.key_out === 1'b0 && fall == 0) fall = i;
            if (kif.key_release === 1'b1) nrel++;
            total++;
            if ({kif.key_out, kif.key_press, kif.key_release} !== {m_out, m_press, m_release}) begin
                bad++;
                $display("FAIL release cyc=%0d got=%b%b%b want=%b%b%b", i, kif.key_out,
                         kif.key_press, kif.key_release, m_out, m_press, m_release);
            end
        end
        total++;
        if (fall != 6 || nrel != 1) begin
            bad++;
            $display("FAIL release_latency fall_tick=%0d releases=%0d want 6 and 1", fall, nrel);
        end
    endtask

    task automatic test_reset_mid();
        int rise = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        total++;
        if ({kif.key_out, kif.key_press, kif.key_release} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid got=%b%b%b want=000", kif.key_out, kif.key_press, kif.key_release);
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0);
            if (kif.key_out === 1'b1 && rise == 0) rise = i;
            total++;
            if ({kif.key_out, kif.key_press, kif.key_release} !== {m_out, m_press, m_release}) begin
                bad++;
                $display("FAIL reset_mid_run cyc=%0d got=%b%b%b want=%b%b%b", i, kif.key_out,
                         kif.key_press, kif.key_release, m_out, m_press, m_release);
            end
        end
        total++;
        if (rise != 6) begin
            bad++;
            $display("FAIL reset_mid_latency rise_tick=%0d want=6", rise);
        end
    endtask

    task automatic test_toggle();
        logic start_out = kif.key_out;
        logic lvl = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(lvl, 1'b0);
            lvl = ~lvl;
            total++;
            if ({kif.key_out, kif.key_press, kif.key_release} !== {start_out, 2'b00} ||
                m_out !== start_out) begin
                bad++;
                $display("FAIL toggle cyc=%0d got=%b%b%b want=%b00", i, kif.key_out,
                         kif.key_press, kif.key_release, start_out);
            end
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   run = 0;
        logic r;
        for (int i = 0; i < 400; i++) begin
            if (run == 0) begin
                lvl = $urandom_range(0, 1);
                run = $urandom_range(1, 7);
            end
            run--;
            r = ($urandom_range(0, 59) == 0);
            tick(lvl, r);
            total++;
            if ({kif.key_out, kif.key_press, kif.key_release} !== {m_out, m_press, m_release} ||
                (kif.key_press & kif.key_release) !== 1'b0) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b%b%b want=%b%b%b", i, kif.key_out,
                         kif.key_press, kif.key_release, m_out, m_press, m_release);
            end
        end
    endtask

    initial begin
        kif.key_in = 1'bx;
        rst        = 1'b1;
        m_out      = IDLE;
        m_press    = 1'b0;
        m_release  = 1'b0;
        streak     = 0;
        pipe       = '{IDLE, IDLE};
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
